// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed 4-digit scan controller, BLANK gap before each lit digit, frame-aligned word updates.
// Latency: all outputs registered; a word accepted in frame N is displayed from the frame N+1 boundary onward.
// Backpressure: word_ready drops after a transfer and rises the cycle after the pending word is applied at a frame boundary.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  code_out,
    output logic [3:0]  an_out,
    output logic        frame_done
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_PRE   = CW'((REFRESH_DIV >= 2) ? REFRESH_DIV - 2 : 0);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  idx;
    logic [15:0] disp;
    logic [15:0] pend_word;
    logic        pend;

    logic        xfer;
    logic        boundary;
    logic        fd_nxt;
    logic [1:0]  idx_nxt;
    logic [15:0] disp_nxt;

    function automatic logic [3:0] lit_an(input logic [1:0] i, input logic [3:0] m);
        logic [3:0] a;
        a    = 4'b1111;
        a[i] = 1'b0;
        return a | m;
    endfunction

    assign xfer     = word_valid && word_ready;
    assign boundary = (state == ST_SHOW) && (cnt == SHOW_LAST) && (idx == 2'd3);
    assign idx_nxt  = idx + 2'd1;
    assign disp_nxt = (boundary && pend) ? pend_word : disp;

    // frame_done is registered, so raise it one cycle ahead of digit 3's last SHOW cycle
    assign fd_nxt = (idx == 2'd3) &&
                    (((state == ST_SHOW) && (REFRESH_DIV >= 2) && (cnt == SHOW_PRE)) ||
                     ((state == ST_BLANK) && (REFRESH_DIV == 1) && (cnt == BLANK_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'hFFFF;
            pend_word  <= 16'h0000;
            pend       <= 1'b0;
            word_ready <= 1'b1;
            code_out   <= 4'hF;
            an_out     <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fd_nxt;
            if (xfer) begin
                pend_word  <= word_in;
                pend       <= 1'b1;
                word_ready <= 1'b0;
            end
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state  <= ST_SHOW;
                        cnt    <= '0;
                        an_out <= lit_an(idx, blank_mask);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state    <= ST_BLANK;
                        cnt      <= '0;
                        idx      <= idx_nxt;
                        an_out   <= 4'b1111;
                        code_out <= disp_nxt[{idx_nxt, 2'b00} +: 4];
                        // ready is low while pending, so this never collides with a capture
                        if (boundary && pend) begin
                            disp       <= pend_word;
                            pend       <= 1'b0;
                            word_ready <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        an_out <= lit_an(idx, blank_mask);
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int DIGP  = RD + BC;
    localparam int FRAME = 4 * DIGP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  blank_mask;
    logic [3:0]  code_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // reference model: cycle number since reset release plus word bookkeeping
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pw;
    bit          m_pend;
    logic [3:0]  m_mask_prev;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .blank_mask (blank_mask),
        .code_out   (code_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t           = 0;
        m_disp      = 16'hFFFF;
        m_pw        = 16'h0000;
        m_pend      = 1'b0;
        m_mask_prev = blank_mask;
    endtask

    task automatic check_all();
        int pos, dig, w;
        logic [3:0] exp_an;
        pos = t % FRAME;
        dig = pos / DIGP;
        w   = pos % DIGP;
        exp_an = 4'b1111;
        if (w >= BC) exp_an = (4'b1111 & ~(4'b0001 << dig)) | m_mask_prev;
        chk("an_out", {12'h0, an_out}, {12'h0, exp_an});
        chk("code_out", {12'h0, code_out}, {12'h0, m_disp[dig*4 +: 4]});
        chk("word_ready", {15'h0, word_ready}, {15'h0, !m_pend});
        chk("frame_done", {15'h0, frame_done}, {15'h0, (pos == FRAME - 1)});
    endtask

    task automatic model_adv(input logic v, input logic [15:0] w);
        bit apply, cap;
        apply = ((t % FRAME) == FRAME - 1) && m_pend;
        cap   = v && !m_pend;
        if (apply) begin
            m_disp = m_pw;
            m_pend = 1'b0;
        end
        if (cap) begin
            m_pw   = w;
            m_pend = 1'b1;
        end
        t++;
    endtask

    // check the current cycle, drive inputs for it, advance the model past the next rising edge
    task automatic step(input logic v, input logic [15:0] w, input logic [3:0] m);
        check_all();
        word_valid  = v;
        word_in     = w;
        blank_mask  = m;
        m_mask_prev = m;
        model_adv(v, w);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] mask;
        int stage;
        int guard;

        rst_n      = 1'b0;
        word_in    = 16'h0000;
        word_valid = 1'b0;
        blank_mask = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // load 3210 at cycle 5, try 7654 while busy, then mask digit 2 for a whole frame
        for (int i = 0; i < 80; i++) begin
            mask = ((i >= 47) && (i < 71)) ? 4'b0100 : 4'b0000;
            if (i == 5)       step(1'b1, 16'h3210, mask);
            else if (i == 10) step(1'b1, 16'h7654, mask);
            else              step(1'b0, 16'h7654, mask);
        end

        // back-to-back: valid held high with A then B
        stage = 0;
        for (int i = 0; i < 120; i++) begin
            if (stage == 2) begin
                step(1'b0, 16'h0000, 4'b0000);
            end else begin
                bit will_cap;
                will_cap = !m_pend;
                step(1'b1, (stage == 0) ? 16'hA5C3 : 16'h1B2D, 4'b0000);
                if (will_cap) stage++;
            end
        end

        // randomized words and masks
        mask = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
            step($urandom_range(0, 5) == 0, 16'($urandom), mask);
        end

        // get a word pending, then reset in the middle of digit 2 SHOW
        guard = 0;
        while (!(m_pend && (t % FRAME) == 2 * DIGP + BC + 1) && guard < 200) begin
            step(!m_pend && ((t % FRAME) < 2 * DIGP), 16'hCAFE, 4'b0000);
            guard++;
        end
        chk("reset_setup", {15'h0, m_pend}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an_out", {12'h0, an_out}, 16'h000F);
        chk("rst_code_out", {12'h0, code_out}, 16'h000F);
        chk("rst_word_ready", {15'h0, word_ready}, 16'h0001);
        chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(i == 30, 16'h4321, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
